// File: rtl/image_mem_arbiter_pkg.sv
// Shared types for the image memory arbiter: return-path tags, grant
// encoding and default address/data widths.
package img_mem_pkg;

  localparam int AW_DEF = 15;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_DISP   = 2'd1,
    TAG_AES_RD = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_AES  = 2'd2
  } gnt_e;

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Client and memory-side bus of the image memory arbiter. The slave
// modport is the arbiter's view; master is the clients/memory view.
interface image_mem_arbiter_if
  import img_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // display read client
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          disp_miss;
  // crypto client
  logic          aes_valid;
  logic          aes_ready;
  logic          aes_we;
  logic [AW:0]   aes_addr;
  logic [DW-1:0] aes_wdata;
  logic [DW-1:0] aes_rdata;
  logic          aes_rvalid;
  // block-RAM side
  logic          mem_en;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  disp_req, disp_addr, aes_valid, aes_we, aes_addr, aes_wdata, mem_dout,
    output disp_rdata, disp_rvalid, disp_miss, aes_ready, aes_rdata, aes_rvalid,
           mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output disp_req, disp_addr, aes_valid, aes_we, aes_addr, aes_wdata, mem_dout,
    input  disp_rdata, disp_rvalid, disp_miss, aes_ready, aes_rdata, aes_rvalid,
           mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/image_mem_arbiter_bank_sel.sv
// Displayed-bank select. A swap request is remembered until the next
// frame start so the visible bank never changes mid-frame.
module img_bank_sel
  import img_mem_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_start,
  input  logic i_bank_swap,
  output logic o_disp_bank
);

  logic r_swap_pend;
  logic r_disp_bank;
  logic w_pend_eff;

  // A swap arriving together with frame_start counts as already pending.
  assign w_pend_eff  = r_swap_pend | i_bank_swap;
  assign o_disp_bank = r_disp_bank;

  // Toggle at frame start when a swap is pending; extra swaps are absorbed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_swap_pend <= 1'b0;
      r_disp_bank <= 1'b0;
    end else if (i_frame_start && w_pend_eff) begin
      r_disp_bank <= ~r_disp_bank;
      r_swap_pend <= 1'b0;
    end else if (i_bank_swap) begin
      r_swap_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Single-port image memory arbiter: fixed display priority with a
// starvation guard for the crypto engine, registered memory issue and a
// two-stage tag pipe that routes read data back to the right client.
module image_mem_arbiter
  import img_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic                ClkPort,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                bank_swap,
  output logic                disp_bank,
  output logic [7:0]          miss_cnt,
  image_mem_arbiter_if.slave  bus
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  gnt_e          w_gnt;
  logic          w_disp_miss;
  logic          w_bank;
  logic [7:0]    r_starve;
  logic [7:0]    r_miss_cnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW:0]   r_mem_addr;
  logic [DW-1:0] r_mem_din;
  tag_e          r_tag_p1;
  tag_e          r_tag_p2;
  logic [DW-1:0] r_disp_rdata;
  logic          r_disp_rvalid;
  logic [DW-1:0] r_aes_rdata;
  logic          r_aes_rvalid;

  img_bank_sel u_bank_sel (
    .i_clk         (ClkPort),
    .i_rst_n       (rst),
    .i_frame_start (frame_start),
    .i_bank_swap   (bank_swap),
    .o_disp_bank   (w_bank)
  );

  // Grant selection: display first unless crypto has waited too long.
  always_comb begin
    w_gnt       = GNT_NONE;
    w_disp_miss = bus.disp_req && (r_starve == STARVE_LIM);
    if (bus.disp_req && (r_starve < STARVE_LIM)) w_gnt = GNT_DISP;
    else if (bus.aes_valid)                       w_gnt = GNT_AES;
  end

  assign bus.aes_ready   = bus.aes_valid && (w_gnt == GNT_AES);
  assign bus.disp_miss   = w_disp_miss;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_din     = r_mem_din;
  assign bus.disp_rdata  = r_disp_rdata;
  assign bus.disp_rvalid = r_disp_rvalid;
  assign bus.aes_rdata   = r_aes_rdata;
  assign bus.aes_rvalid  = r_aes_rvalid;
  assign disp_bank       = w_bank;
  assign miss_cnt        = r_miss_cnt;

  // Starvation counter and dropped-display counter.
  always_ff @(posedge ClkPort or negedge rst) begin
    if (!rst) begin
      r_starve   <= 8'd0;
      r_miss_cnt <= 8'd0;
    end else begin
      if (w_gnt == GNT_AES || !bus.aes_valid) r_starve <= 8'd0;
      else                                    r_starve <= sat_inc(r_starve, STARVE_LIM);
      if (w_disp_miss) r_miss_cnt <= sat_inc(r_miss_cnt, 8'hFF);
    end
  end

  // Stage p1: register the granted request onto the memory port and tag it.
  always_ff @(posedge ClkPort or negedge rst) begin
    if (!rst) begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_tag_p1   <= TAG_NONE;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_tag_p1 <= TAG_NONE;
      case (w_gnt)
        GNT_DISP: begin
          r_mem_en   <= 1'b1;
          r_mem_addr <= {w_bank, bus.disp_addr};
          r_tag_p1   <= TAG_DISP;
        end
        GNT_AES: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= bus.aes_we;
          r_mem_addr <= bus.aes_addr;
          r_mem_din  <= bus.aes_wdata;
          r_tag_p1   <= bus.aes_we ? TAG_NONE : TAG_AES_RD;
        end
        default: ;
      endcase
    end
  end

  // Stage p2: memory data valid; route it to the owning client on the next edge.
  always_ff @(posedge ClkPort or negedge rst) begin
    if (!rst) begin
      r_tag_p2      <= TAG_NONE;
      r_disp_rdata  <= '0;
      r_disp_rvalid <= 1'b0;
      r_aes_rdata   <= '0;
      r_aes_rvalid  <= 1'b0;
    end else begin
      r_tag_p2      <= r_tag_p1;
      r_disp_rvalid <= (r_tag_p2 == TAG_DISP);
      r_aes_rvalid  <= (r_tag_p2 == TAG_AES_RD);
      if (r_tag_p2 == TAG_DISP)   r_disp_rdata <= bus.mem_dout;
      if (r_tag_p2 == TAG_AES_RD) r_aes_rdata  <= bus.mem_dout;
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: directed stimulus pushes expected read
// returns into queues; a negedge monitor pops and compares them.
module tb_image_mem_arbiter;
  import img_mem_pkg::*;

  localparam int AW = 15;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bank_swap = 1'b0;
  logic       disp_bank;
  logic [7:0] miss_cnt;

  image_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  image_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .ClkPort     (clk),
    .rst         (rst_n),
    .frame_start (frame_start),
    .bank_swap   (bank_swap),
    .disp_bank   (disp_bank),
    .miss_cnt    (miss_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: read data equals the low address byte, one cycle after mem_en
  always @(posedge clk) if (bus.mem_en && !bus.mem_we) bus.mem_dout <= bus.mem_addr[7:0];

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q_disp[$];
  exp_t q_aes[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_disp(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 3;
    q_disp.push_back(e);
  endtask

  task automatic exp_aes(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 3;
    q_aes.push_back(e);
  endtask

  // monitor: every rvalid pulse must match the oldest expected return
  always @(negedge clk) begin
    exp_t e;
    if (bus.disp_rvalid) begin
      if (q_disp.size() == 0) chk("disp_unexpected_rvalid", 1, 0);
      else begin
        e = q_disp.pop_front();
        chk("disp_rdata", bus.disp_rdata, e.data);
        chk("disp_latency", cyc, e.due);
      end
    end
    if (bus.aes_rvalid) begin
      if (q_aes.size() == 0) chk("aes_unexpected_rvalid", 1, 0);
      else begin
        e = q_aes.pop_front();
        chk("aes_rdata", bus.aes_rdata, e.data);
        chk("aes_latency", cyc, e.due);
      end
    end
  end

  initial begin
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.aes_valid = 1'b0;
    bus.aes_we    = 1'b0;
    bus.aes_addr  = '0;
    bus.aes_wdata = '0;
    bus.mem_dout  = '0;

    // reset state
    repeat (3) tick();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_disp_rvalid", bus.disp_rvalid, 0);
    chk("rst_aes_rvalid", bus.aes_rvalid, 0);
    chk("rst_disp_rdata", bus.disp_rdata, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_disp_bank", disp_bank, 0);
    chk("rst_aes_ready", bus.aes_ready, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // display reads every 4th cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.disp_req  = 1'b1;
      bus.disp_addr = 15'(16'h0010 + i);
      exp_disp(8'(8'h10 + i));
      tick();
      bus.disp_req = 1'b0;
      chk("disp_mem_en", bus.mem_en, 1);
      chk("disp_mem_we", bus.mem_we, 0);
      chk("disp_mem_addr", bus.mem_addr, 16'h0010 + i);
      tick();
      tick();
    end

    // crypto read alongside display reads
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.disp_req  = 1'b1;
      bus.disp_addr = 15'(16'h0014 + i);
      bus.aes_valid = 1'b1;
      bus.aes_we    = 1'b0;
      bus.aes_addr  = {1'b1, 15'h0020};
      #1 chk("aes_ready_blocked", bus.aes_ready, 0);
      exp_disp(8'(8'h14 + i));
      tick();
      bus.disp_req = 1'b0;
      #1 chk("aes_ready_free", bus.aes_ready, 1);
      exp_aes(8'h20);
      tick();
      bus.aes_valid = 1'b0;
      chk("aes_mem_addr", bus.mem_addr, {1'b1, 15'h0020});
      tick();
      tick();
    end

    // starvation guard: display held high, crypto forced every 9th cycle
    tick();
    bus.aes_valid = 1'b1;
    bus.aes_we    = 1'b0;
    bus.aes_addr  = {1'b0, 15'h0030};
    for (int k = 0; k < 18; k++) begin
      logic acc;
      acc = ((k % 9) == 8);
      bus.disp_req  = 1'b1;
      bus.disp_addr = 15'(16'h0040 + k);
      #1;
      chk("starve_aes_ready", bus.aes_ready, acc);
      chk("starve_disp_miss", bus.disp_miss, acc);
      if (acc) exp_aes(8'h30);
      else     exp_disp(8'(8'h40 + k));
      if (k == 9) chk("miss_cnt_first", miss_cnt, 1);
      tick();
    end
    bus.disp_req  = 1'b0;
    bus.aes_valid = 1'b0;
    repeat (4) tick();
    chk("miss_cnt_second", miss_cnt, 2);

    // bank swap at a frame boundary
    bank_swap = 1'b1;
    tick();
    bank_swap = 1'b0;
    repeat (38) tick();
    chk("bank_pending", disp_bank, 0);
    frame_start   = 1'b1;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 15'h0050;
    exp_disp(8'h50);
    chk("bank_at_frame_start", disp_bank, 0);
    tick();
    frame_start   = 1'b0;
    bus.disp_addr = 15'h0051;
    exp_disp(8'h51);
    chk("bank_after_frame", disp_bank, 1);
    chk("old_bank_addr", bus.mem_addr, {1'b0, 15'h0050});
    tick();
    bus.disp_req = 1'b0;
    chk("new_bank_addr", bus.mem_addr, {1'b1, 15'h0051});
    tick();
    bank_swap   = 1'b1;
    frame_start = 1'b1;
    tick();
    bank_swap   = 1'b0;
    frame_start = 1'b0;
    chk("bank_simultaneous", disp_bank, 0);
    tick();
    bank_swap = 1'b1;
    tick();
    bank_swap = 1'b0;
    tick();
    bank_swap = 1'b1;
    tick();
    bank_swap = 1'b0;
    chk("bank_double_pending", disp_bank, 0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("bank_single_toggle", disp_bank, 1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("bank_no_pending", disp_bank, 1);

    // crypto write: no response
    tick();
    bus.aes_valid = 1'b1;
    bus.aes_we    = 1'b1;
    bus.aes_addr  = {1'b0, 15'h0100};
    bus.aes_wdata = 8'hA5;
    #1 chk("wr_aes_ready", bus.aes_ready, 1);
    tick();
    bus.aes_valid = 1'b0;
    bus.aes_we    = 1'b0;
    chk("wr_mem_en", bus.mem_en, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_din", bus.mem_din, 8'hA5);
    chk("wr_mem_addr", bus.mem_addr, {1'b0, 15'h0100});
    repeat (4) tick();

    // reset with two reads in flight
    bus.disp_req  = 1'b1;
    bus.disp_addr = 15'h0060;
    tick();
    bus.disp_req  = 1'b0;
    bus.aes_valid = 1'b1;
    bus.aes_addr  = {1'b0, 15'h0070};
    tick();
    bus.aes_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("inrst_mem_en", bus.mem_en, 0);
    chk("inrst_disp_rdata", bus.disp_rdata, 0);
    chk("inrst_aes_rdata", bus.aes_rdata, 0);
    chk("inrst_disp_bank", disp_bank, 0);
    chk("inrst_miss_cnt", miss_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_miss_cnt", miss_cnt, 0);
    chk("post_rst_disp_bank", disp_bank, 0);
    chk("post_rst_disp_rdata", bus.disp_rdata, 0);

    chk("disp_queue_drained", q_disp.size(), 0);
    chk("aes_queue_drained", q_aes.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Single-port arbiter for the shared image memory. Two requesters share it: the VGA sprite fetch path (display) and the AES crypto engine. Display reads have fixed priority, and a starvation guard keeps the crypto engine from being locked out. The block also owns the displayed-image bank select, which swaps only on frame boundaries. It sits between the sprite renderer/crypto engine and the block-RAM wrapper, all clocked on ClkPort.

## Interface
Parameters:
- AW, 15, client address width; memory address is AW+1 (MSB = bank)
- DW, 8, data width
- STARVE_MAX, 8, consecutive denied crypto cycles before a forced crypto grant (range 1..255)

Ports:
- ClkPort  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- disp_req  in  1  display read strobe, one cycle per pixel fetch
- disp_addr  in  AW  display read address, qualified by disp_req
- disp_rdata  out  DW  last display read data; holds between returns
- disp_rvalid  out  1  one-cycle pulse, disp_rdata updated
- disp_miss  out  1  one-cycle pulse, display request dropped
- frame_start  in  1  one-cycle pulse at start of vertical blank
- bank_swap  in  1  one-cycle pulse requesting a displayed-bank toggle
- disp_bank  out  1  bank currently displayed
- aes_valid  in  1  crypto request valid
- aes_ready  out  1  crypto request accepted this cycle (combinational)
- aes_we  in  1  1 = write, 0 = read
- aes_addr  in  AW+1  crypto address including bank bit
- aes_wdata  in  DW  write data
- aes_rdata  out  DW  crypto read data
- aes_rvalid  out  1  one-cycle pulse, aes_rdata valid
- miss_cnt  out  8  saturating count of dropped display requests
- mem_en  out  1  memory enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW+1  memory address (registered)
- mem_din  out  DW  memory write data (registered)
- mem_dout  in  DW  memory read data, one cycle after mem_en

## Operation
- Per cycle, the grant is chosen among NONE, DISP and AES.
- Grant rule: if disp_req and starve_cnt < STARVE_MAX, grant DISP. Otherwise, if aes_valid, grant AES. Otherwise grant NONE.
- aes_ready = aes_valid && grant==AES.
- A DISP grant issues mem_addr = {disp_bank, disp_addr}, with mem_we = 0.
- An AES grant issues aes_addr, aes_we and aes_wdata unchanged.
- starve_cnt:
  - increments, saturating at STARVE_MAX, on each cycle with aes_valid && !aes_ready;
  - clears on an AES grant, and clears when aes_valid is low.
- Forced grant: if disp_req is high while starve_cnt == STARVE_MAX, the display request is dropped.
  - disp_miss pulses in that cycle.
  - miss_cnt increments and saturates at 255.
  - No disp_rvalid is produced for the dropped request; disp_rdata keeps its old value.
- Return path: a 2-stage tag pipeline (NONE/DISP/AES_RD) follows each issued request. Writes tag as NONE.
  - A DISP tag at stage 2 loads disp_rdata from mem_dout and pulses disp_rvalid.
  - An AES_RD tag at stage 2 loads aes_rdata and pulses aes_rvalid.
- Bank swap:
  - bank_swap sets swap_pend.
  - On frame_start with swap_pend set, disp_bank toggles and swap_pend clears.
  - If bank_swap and frame_start arrive in the same cycle, the toggle happens immediately.
  - A second bank_swap while pending is absorbed (no double toggle).
- Reset: all outputs and registers go to 0, disp_bank = 0 and tags = NONE. Reads in flight when reset asserts are discarded and produce no rvalid after release.

## Timing
- Request in cycle t: mem_en/mem_we/mem_addr/mem_din asserted in cycle t+1. mem_dout is valid in t+2. disp_rdata/aes_rdata and the rvalid pulse are visible in t+3.
- Read latency is exactly 3 cycles for both clients. Writes have no response.
- One request per cycle maximum. Back-to-back grants are fully pipelined.
- aes_valid/aes_addr/aes_we/aes_wdata must stay stable until aes_ready is high.
- disp_req is not held: if it is not granted, it is dropped.
- disp_bank changes on the clock edge after frame_start. A read issued in the same cycle as frame_start uses the old bank.
- mem_en = 0 in any cycle following a NONE grant.

## Structure
- Shared package img_mem_pkg holds: the tag enum (TAG_NONE, TAG_DISP, TAG_AES_RD), the grant enum (GNT_NONE, GNT_DISP, GNT_AES), and the AW/DW defaults.
- One sub-module, img_bank_sel, holds the swap_pend/disp_bank logic.
- The grant logic, starve counter, tag pipe and hold registers are inline in the top module.

## Test plan
- Reset, then disp_req every 4th cycle with addr 0x0010..0x0013 and mem model returning addr[7:0] → disp_rvalid at t+3 with data 0x10..0x13; mem_addr MSB = 0.
- aes_valid read to 0x1_0020, concurrent with disp_req every 4th cycle → aes_ready only in non-display cycles; aes_rvalid 3 cycles after accept with data 0x20.
- disp_req held high continuously, aes_valid high, STARVE_MAX = 8 → after 8 denied cycles, aes_ready = 1 and disp_miss = 1 in the same cycle, miss_cnt = 1; the pattern repeats every 9 cycles.
- bank_swap at cycle 10, frame_start at 50 → disp_bank = 1 from cycle 51. Simultaneous bank_swap + frame_start → toggles back to 0 the next cycle. Two bank_swaps before one frame_start → single toggle.
- AES write 0xA5 to 0x0_0100 → mem_we = 1, mem_din = 0xA5 in t+1; no aes_rvalid.
- Assert rst with two reads in flight → all outputs 0. No rvalid pulses after release; miss_cnt = 0, disp_bank = 0.
